uart_bus_driver: RTL and testbench

//  Io-bus initiator that owns one uart instance: drives its 4-bit register bus so clients see byte streams, not registers.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_byte_fifo.sv | 40 ++++
 rtl/uart_bus_driver.sv | 124 ++++++++++++
 tb/tb_uart_bus_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: uart register map, status bit positions and driver FSM states
package uart_pkg;
   localparam logic [3:0] UART_RXDATA = 4'd0;
   localparam logic [3:0] UART_TXDATA = 4'd1;
   localparam logic [3:0] UART_STATUS = 4'd2;
   localparam logic [3:0] UART_INVERT = 4'd3;
   localparam logic [3:0] UART_DIVL   = 4'd4;
   localparam logic [3:0] UART_DIVH   = 4'd5;
   localparam int ST_TX = 0;
   localparam int ST_RX = 1;
   typedef enum logic [2:0] {CFG_DL, CFG_DH, CFG_INV, IDLE, POLL, RXRD, TXWR, TXCLR} state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH-entry byte FIFO; push and pop in the same cycle both succeed even when full or empty
//   clk, reset  clock, synchronous active-high reset
//   push, din   write request and byte
//   pop         read request
//   head        oldest byte (din passes straight through while empty)
//   full, empty occupancy flags
module uart_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   // pointers carry one extra wrap bit so equal low bits mean full when the wrap bits differ
   assign empty = wp == rp;
   assign full = wp == {~rp[AW], rp[AW-1:0]};
   assign do_pop = pop && (!empty || push);
   assign do_push = push && (!full || pop);
   assign head = empty ? din : mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_bus_driver.sv
// uart_bus_driver: io-bus initiator that configures one uart and turns its register interface into TX/RX byte streams
//   clk, reset                               clock, synchronous active-high reset
//   tx_valid, tx_data, tx_ready              client bytes into the TX FIFO
//   rx_valid, rx_data, rx_ready              RX FIFO bytes out to the client
//   rx_overrun                               sticky: a received byte was dropped on a full RX FIFO
//   cfg_done                                 divider/inversion writes complete
//   uart_interrupt                           uart interrupt line
//   io_addr, io_wdata, io_write, io_read     registered uart register bus, at most one op per cycle
//   io_rdata                                 uart read data, valid during the io_read cycle
module uart_bus_driver
   import uart_pkg::*;
#(
   parameter logic [11:0] DIV       = 12'd43,
   parameter logic        RX_INVERT = 1'b0,
   parameter logic        TX_INVERT = 1'b0,
   parameter int          DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       rx_overrun,
   output logic       cfg_done,
   input  logic       uart_interrupt,
   output logic [3:0] io_addr,
   output logic [7:0] io_wdata,
   output logic       io_write,
   output logic       io_read,
   input  logic [7:0] io_rdata
);
   state_t state;
   logic tx_busy, tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
   logic [7:0] tx_head;
   assign tx_ready = !tx_full;
   assign rx_valid = !rx_empty;
   // runtime ops are registered on entry to their state, so POLL and RXRD see their own read data on io_rdata
   assign tx_pop = !tx_empty && (state == IDLE ? !uart_interrupt && !tx_busy
                                               : state == POLL && !io_rdata[ST_RX] && io_rdata[ST_TX]);
   assign rx_push = state == RXRD && !rx_full;
   uart_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_valid && tx_ready), .din(tx_data), .pop(tx_pop),
      .head(tx_head), .full(tx_full), .empty(tx_empty)
   );
   uart_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .din(io_rdata), .pop(rx_valid && rx_ready),
      .head(rx_data), .full(rx_full), .empty(rx_empty)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CFG_DL;
         io_addr <= '0;
         io_wdata <= '0;
         io_write <= 1'b0;
         io_read <= 1'b0;
         tx_busy <= 1'b0;
         cfg_done <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         io_write <= 1'b0;
         io_read <= 1'b0;
         case (state)
            CFG_DL: begin
               state <= CFG_DH;
               io_write <= 1'b1;
               io_addr <= UART_DIVL;
               io_wdata <= DIV[7:0];
            end
            CFG_DH: begin
               state <= CFG_INV;
               io_write <= 1'b1;
               io_addr <= UART_DIVH;
               io_wdata <= {4'b0, DIV[11:8]};
            end
            CFG_INV: begin
               state <= IDLE;
               io_write <= 1'b1;
               io_addr <= UART_INVERT;
               io_wdata <= {6'b0, RX_INVERT, TX_INVERT};
            end
            IDLE: begin
               cfg_done <= 1'b1;
               if (uart_interrupt) begin
                  state <= POLL;
                  io_read <= 1'b1;
                  io_addr <= UART_STATUS;
               end
            end
            POLL: begin
               state <= IDLE;
               if (io_rdata[ST_RX]) begin
                  state <= RXRD;
                  io_read <= 1'b1;
                  io_addr <= UART_RXDATA;
               end else if (io_rdata[ST_TX]) begin
                  tx_busy <= 1'b0;
                  if (tx_empty) begin
                     state <= TXCLR;
                     io_write <= 1'b1;
                     io_addr <= UART_STATUS;
                     io_wdata <= 8'h01;
                  end
               end
            end
            RXRD: begin
               state <= IDLE;
               if (rx_full) rx_overrun <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         // a TX FIFO pop always becomes the reg-1 write, overriding the IDLE/POLL defaults above
         if (tx_pop) begin
            state <= TXWR;
            io_write <= 1'b1;
            io_addr <= UART_TXDATA;
            io_wdata <= tx_head;
            tx_busy <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_bus_driver.sv
// tb_uart_bus_driver: scoreboard bench with a loopback uart model (tx wired to rx, DIV=1)
module tb_uart_bus_driver;
   localparam int BYTE_CYC = 40;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic rx_ready = 1'b1;
   logic tx_ready, rx_valid, rx_overrun, cfg_done, uart_interrupt, io_write, io_read;
   logic [7:0] rx_data, io_wdata, io_rdata;
   logic [3:0] io_addr;
   logic [7:0] m_rxbuf, m_shift;
   logic m_rxint, m_txint;
   int m_cnt, cyc;
   int errors = 0, checks = 0;
   int wr1_cnt = 0, clr_cnt = 0, rd0_cnt = 0, first_wr1 = -1;
   logic tx_ok = 1'b1;
   logic [7:0] exp_tx[$], exp_rx[$];
   logic [11:0] exp_cfg[$];
   always #5 clk = ~clk;
   uart_bus_driver #(.DIV(12'd1), .RX_INVERT(1'b0), .TX_INVERT(1'b0), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
      .cfg_done(cfg_done), .uart_interrupt(uart_interrupt), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_write(io_write), .io_read(io_read), .io_rdata(io_rdata)
   );
   // uart model: a reg-1 write comes back on RX BYTE_CYC cycles later, setting both interrupts; a set beats a clear
   always @(posedge clk) begin
      if (reset) begin
         m_rxint <= 1'b0;
         m_txint <= 1'b0;
         m_cnt <= 0;
         m_rxbuf <= 8'h00;
         m_shift <= 8'h00;
      end else begin
         if (io_read && io_addr == 4'd0) m_rxint <= 1'b0;
         if (io_write && io_addr == 4'd2) begin
            if (io_wdata[0]) m_txint <= 1'b0;
            if (io_wdata[1]) m_rxint <= 1'b0;
         end
         if (io_write && io_addr == 4'd1) begin
            m_shift <= io_wdata;
            m_cnt <= BYTE_CYC;
            m_txint <= 1'b0;
         end else if (m_cnt == 1) begin
            m_cnt <= 0;
            m_txint <= 1'b1;
            m_rxint <= 1'b1;
            m_rxbuf <= m_shift;
         end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
      end
   end
   assign uart_interrupt = m_rxint | m_txint;
   assign io_rdata = io_addr == 4'd0 ? m_rxbuf : io_addr == 4'd2 ? {6'b0, m_rxint, m_txint} : 8'h00;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic bad(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask
   // bus monitor: config writes and reg-1 bytes are scored against queues, reg-1 writes need a tx-done status read between them
   initial forever begin
      @(negedge clk);
      if (reset) tx_ok = 1'b1;
      else begin
         if (io_write) begin
            if (io_addr == 4'd1) begin
               wr1_cnt++;
               if (first_wr1 < 0) first_wr1 = cyc;
               chk("tx_after_status", 32'(tx_ok), 32'd1);
               tx_ok = 1'b0;
               if (exp_tx.size() == 0) bad("tx_unexpected", 32'(io_wdata));
               else chk("tx_byte", 32'(io_wdata), 32'(exp_tx.pop_front()));
            end else if (io_addr == 4'd2) begin
               clr_cnt++;
               chk("txclr_data", 32'(io_wdata), 32'h01);
            end else if (exp_cfg.size() == 0) bad("cfg_unexpected", 32'({io_addr, io_wdata}));
            else chk("cfg_write", 32'({io_addr, io_wdata}), 32'(exp_cfg.pop_front()));
         end
         if (io_read) begin
            chk("read_after_cfg", 32'(cfg_done), 32'd1);
            if (io_addr == 4'd0) rd0_cnt++;
            else if (io_addr == 4'd2 && io_rdata[0]) tx_ok = 1'b1;
         end
      end
   end
   initial forever begin
      @(negedge clk);
      if (!reset && rx_valid && rx_ready) begin
         if (exp_rx.size() == 0) bad("rx_unexpected", 32'(rx_data));
         else chk("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
   end
   task automatic push(input logic [7:0] b, input bit expect_rx);
      int n = 0;
      tx_valid = 1'b1;
      tx_data = b;
      while (!tx_ready && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!tx_ready) bad("push_timeout", 32'(b));
      else begin
         exp_tx.push_back(b);
         if (expect_rx) exp_rx.push_back(b);
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
   endtask
   task automatic wait_quiet();
      int q = 0, n = 0;
      while (q < 10 && n < 5000) begin
         @(negedge clk);
         n++;
         q = (!io_write && !io_read && !uart_interrupt && m_cnt == 0) ? q + 1 : 0;
      end
      if (q < 10) bad("quiet_timeout", 32'(n));
   endtask
   task automatic load_cfg();
      exp_cfg.push_back({4'd4, 8'h01});
      exp_cfg.push_back({4'd5, 8'h00});
      exp_cfg.push_back({4'd3, 8'h00});
   endtask
   initial begin
      int base_wr, base_rd, base_clr, n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_io_write", 32'(io_write), 32'd0);
      chk("rst_io_read", 32'(io_read), 32'd0);
      chk("rst_io_addr", 32'(io_addr), 32'd0);
      chk("rst_io_wdata", 32'(io_wdata), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_cfg_done", 32'(cfg_done), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      load_cfg();
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("tx_ready_cfg", 32'(tx_ready), 32'd1);
      tx_valid = 1'b1;
      tx_data = 8'hA5;
      exp_tx.push_back(8'hA5);
      exp_rx.push_back(8'hA5);
      @(negedge clk);
      chk("c1_write", 32'(io_write), 32'd1);
      chk("c1_cfg_done", 32'(cfg_done), 32'd0);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      @(negedge clk);
      chk("c2_write", 32'(io_write), 32'd1);
      @(negedge clk);
      chk("c3_write", 32'(io_write), 32'd1);
      chk("c3_cfg_done", 32'(cfg_done), 32'd0);
      @(negedge clk);
      chk("c4_cfg_done", 32'(cfg_done), 32'd1);
      chk("cfg_all_seen", 32'(exp_cfg.size()), 32'd0);
      wait_quiet();
      chk("a5_first_wr1_cycle_ge4", 32'(first_wr1 >= 4), 32'd1);
      chk("a5_wr1_count", 32'(wr1_cnt), 32'd1);
      chk("a5_txclr_count", 32'(clr_cnt), 32'd1);
      chk("a5_int_clear", 32'(uart_interrupt), 32'd0);
      chk("a5_rx_drained", 32'(exp_rx.size()), 32'd0);
      base_wr = wr1_cnt;
      base_clr = clr_cnt;
      @(posedge clk);
      #1;
      push(8'h01, 1'b1);
      push(8'h02, 1'b1);
      push(8'h03, 1'b1);
      wait_quiet();
      chk("seq3_wr1_count", 32'(wr1_cnt - base_wr), 32'd3);
      chk("seq3_txclr_count", 32'(clr_cnt - base_clr), 32'd1);
      chk("seq3_rx_drained", 32'(exp_rx.size()), 32'd0);
      chk("seq3_int_clear", 32'(uart_interrupt), 32'd0);
      @(posedge clk);
      #1 rx_ready = 1'b0;
      chk("ovr_before", 32'(rx_overrun), 32'd0);
      base_rd = rd0_cnt;
      push(8'h10, 1'b1);
      push(8'h20, 1'b1);
      push(8'h30, 1'b1);
      push(8'h40, 1'b1);
      push(8'h50, 1'b0);
      wait_quiet();
      chk("ovr_flag", 32'(rx_overrun), 32'd1);
      chk("ovr_rd0_count", 32'(rd0_cnt - base_rd), 32'd5);
      chk("ovr_int_clear", 32'(uart_interrupt), 32'd0);
      chk("ovr_rx_valid", 32'(rx_valid), 32'd1);
      chk("ovr_rx_head", 32'(rx_data), 32'h10);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      n = 0;
      while (rx_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ovr_drained", 32'(rx_valid), 32'd0);
      chk("ovr_rx_queue", 32'(exp_rx.size()), 32'd0);
      chk("ovr_sticky", 32'(rx_overrun), 32'd1);
      @(posedge clk);
      #1;
      base_wr = wr1_cnt;
      push(8'h5A, 1'b1);
      n = 0;
      while (wr1_cnt == base_wr && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_byte_sent", 32'(wr1_cnt - base_wr), 32'd1);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      exp_rx.delete();
      load_cfg();
      base_wr = wr1_cnt;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mrst_io_write", 32'(io_write), 32'd0);
      chk("mrst_io_read", 32'(io_read), 32'd0);
      chk("mrst_io_addr", 32'(io_addr), 32'd0);
      chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
      chk("mrst_rx_overrun", 32'(rx_overrun), 32'd0);
      chk("mrst_cfg_done", 32'(cfg_done), 32'd0);
      wait_quiet();
      chk("mrst_cfg_repeat", 32'(exp_cfg.size()), 32'd0);
      chk("mrst_cfg_done_again", 32'(cfg_done), 32'd1);
      chk("mrst_no_replay", 32'(wr1_cnt - base_wr), 32'd0);
      chk("mrst_rx_empty", 32'(rx_valid), 32'd0);
      chk("end_tx_queue", 32'(exp_tx.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end
endmodule
